// File: rtl/reg_write_arb_pkg.sv
// Shared types for the register-file write-port arbiter: register address,
// the r15 (PC) address constant, the holding-slot record and the grant code.
package reg_write_arb_pkg;

    typedef logic [3:0] reg_addr_t;

    // r15 is the PC; the register file itself only stores r0-r14.
    localparam reg_addr_t PC_ADDR = 4'hF;

    // Width of the data field carried in a slot. The top-level DATA_WIDTH
    // is cast into and out of this field.
    localparam int WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     full;
        reg_addr_t                addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_slot_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_t;

endpackage

// File: rtl/reg_write_arbiter_wb_slot.sv
// One-entry writeback holding slot. Accepts a request on valid&&ready,
// empties when granted, and can be refilled in the same cycle it is granted.
module wb_slot
    import reg_write_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  reg_addr_t             addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  grant_i,
    output logic                  ready_o,
    output logic                  load_o,
    output wb_slot_t              slot_o
);

    wb_slot_t slot_q;
    wb_slot_t slot_d;

    // Ready depends only on slot state and this cycle's grant, never on valid.
    assign ready_o = !slot_q.full || grant_i;
    assign load_o  = valid_i && ready_o;
    assign slot_o  = slot_q;

    // Next slot contents: a load wins over the grant-driven drain.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        slot_d = slot_q;
        if (load_o) begin
            slot_d.full = 1'b1;
            slot_d.addr = addr_i;
            slot_d.data = WB_DATA_WIDTH'(data_i);
        end else if (grant_i) begin
            slot_d.full = 1'b0;
        end
    end

    // Slot register; reset discards any pending entry.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter between the execute stage (A) and the
// memory/load stage (B). Priority: single full slot, then oldest entry on a
// same-address collision, then A when it has starved, otherwise B. Writes to
// r15 go to the PC-write outputs instead of the register file.
// Optional feature macro: REG_WRITE_ARB_PENDING_EN (drives pending_mask;
// when undefined the port is tied to zero).
module reg_write_arbiter
    import reg_write_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [3:0]            a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [3:0]            b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  write_enable3,
    output logic [3:0]            write_addr3,
    output logic [DATA_WIDTH-1:0] write_data3,
    output logic                  pc_write_enable,
    output logic [DATA_WIDTH-1:0] pc_write_data,
    output logic [15:0]           pending_mask
);

    wb_slot_t   slot_a;
    wb_slot_t   slot_b;
    wb_slot_t   sel;
    grant_t     grant;
    logic       a_load;
    logic       b_load;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       a_older_q;   // 1: A holds the older entry; cleared means B is older
    logic       a_older_d;

    wb_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk     (clk),
        .reset   (reset),
        .valid_i (a_valid),
        .addr_i  (a_addr),
        .data_i  (a_data),
        .grant_i (grant == GRANT_A),
        .ready_o (a_ready),
        .load_o  (a_load),
        .slot_o  (slot_a)
    );

    wb_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clk     (clk),
        .reset   (reset),
        .valid_i (b_valid),
        .addr_i  (b_addr),
        .data_i  (b_data),
        .grant_i (grant == GRANT_B),
        .ready_o (b_ready),
        .load_o  (b_load),
        .slot_o  (slot_b)
    );

    // Pick at most one slot to drain this cycle.
    always_comb begin
        grant = GRANT_NONE;
        if (slot_a.full && !slot_b.full) begin
            grant = GRANT_A;
        end else if (!slot_a.full && slot_b.full) begin
            grant = GRANT_B;
        end else if (slot_a.full && slot_b.full) begin
            if (slot_a.addr == slot_b.addr) begin
                grant = a_older_q ? GRANT_A : GRANT_B;
            end else if (starve_q >= 4'(STARVE_LIMIT)) begin
                grant = GRANT_A;
            end else begin
                grant = GRANT_B;
            end
        end
    end

    // Route the granted entry to the register file or, for r15, to the PC.
    always_comb begin
        sel             = (grant == GRANT_A) ? slot_a : slot_b;
        write_enable3   = 1'b0;
        write_addr3     = '0;
        write_data3     = '0;
        pc_write_enable = 1'b0;
        pc_write_data   = '0;
        if (grant != GRANT_NONE) begin
            if (sel.addr == PC_ADDR) begin
                pc_write_enable = 1'b1;
                pc_write_data   = DATA_WIDTH'(sel.data);
            end else begin
                write_enable3 = 1'b1;
                write_addr3   = sel.addr;
                write_data3   = DATA_WIDTH'(sel.data);
            end
        end
    end

    // Starvation count and relative age of the two entries.
    always_comb begin
        if (!slot_a.full || grant == GRANT_A) begin
            starve_d = 4'd0;
        end else if (starve_q == 4'hF) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 4'd1;
        end
        // The slot loaded most recently is the younger one; a simultaneous
        // load of both leaves B as the older entry.
        if (b_load && !a_load) begin
            a_older_d = 1'b1;
        end else if (a_load) begin
            a_older_d = 1'b0;
        end else begin
            a_older_d = a_older_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q  <= 4'd0;
            a_older_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            a_older_q <= a_older_d;
        end
    end

`ifdef REG_WRITE_ARB_PENDING_EN
    // In-flight destination registers, as held before this cycle's grant.
    always_comb begin
        pending_mask = 16'h0000;
        if (slot_a.full) pending_mask[slot_a.addr] = 1'b1;
        if (slot_b.full) pending_mask[slot_b.addr] = 1'b1;
    end
`else
    assign pending_mask = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// random traffic, compared against a timestamp-based reference model.
module tb_reg_write_arbiter;

    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [3:0]    a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          write_enable3;
    logic [3:0]    write_addr3;
    logic [DW-1:0] write_data3;
    logic          pc_write_enable;
    logic [DW-1:0] pc_write_data;
    logic [15:0]   pending_mask;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk             (clk),
        .reset           (reset),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_addr          (a_addr),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_addr          (b_addr),
        .b_data          (b_data),
        .write_enable3   (write_enable3),
        .write_addr3     (write_addr3),
        .write_data3     (write_data3),
        .pc_write_enable (pc_write_enable),
        .pc_write_data   (pc_write_data),
        .pending_mask    (pending_mask)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: each slot remembers the edge at which it was loaded;
    // the older entry has the smaller stamp, ties go to B.
    typedef struct {
        bit        full;
        bit [3:0]  addr;
        bit [31:0] data;
        int        stamp;
    } mslot_t;

    mslot_t ma, mb;
    int     mstarve;
    int     edge_no;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma      = '{1'b0, 4'd0, 32'd0, 0};
        mb      = '{1'b0, 4'd0, 32'd0, 0};
        mstarve = 0;
    endtask

    // 0 = none, 1 = A, 2 = B
    function automatic int mgrant();
        if (ma.full && !mb.full) return 1;
        if (!ma.full && mb.full) return 2;
        if (!ma.full && !mb.full) return 0;
        if (ma.addr == mb.addr) return (ma.stamp < mb.stamp) ? 1 : 2;
        if (mstarve >= SL) return 1;
        return 2;
    endfunction

    task automatic check_outputs(input string ctx);
        int        g;
        mslot_t    s;
        bit        we, pe;
        bit [15:0] mask;
        g    = mgrant();
        s    = (g == 1) ? ma : mb;
        we   = (g != 0) && (s.addr != 4'hF);
        pe   = (g != 0) && (s.addr == 4'hF);
        mask = 16'h0000;
`ifdef REG_WRITE_ARB_PENDING_EN
        if (ma.full) mask = mask | (16'h0001 << ma.addr);
        if (mb.full) mask = mask | (16'h0001 << mb.addr);
`endif
        check({ctx, ".a_ready"}, 32'(a_ready),         32'(!ma.full || g == 1));
        check({ctx, ".b_ready"}, 32'(b_ready),         32'(!mb.full || g == 2));
        check({ctx, ".we"},      32'(write_enable3),   32'(we));
        check({ctx, ".waddr"},   32'(write_addr3),     we ? 32'(s.addr) : 32'd0);
        check({ctx, ".wdata"},   32'(write_data3),     we ? s.data : 32'd0);
        check({ctx, ".pc_we"},   32'(pc_write_enable), 32'(pe));
        check({ctx, ".pc_data"}, 32'(pc_write_data),   pe ? s.data : 32'd0);
        check({ctx, ".mask"},    32'(pending_mask),    32'(mask));
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, then advance the
    // model across the rising edge.
    task automatic step(input bit av, input bit [3:0] aa, input bit [31:0] ad,
                        input bit bv, input bit [3:0] ba, input bit [31:0] bd,
                        input string ctx);
        int g;
        bit ar, br;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check_outputs(ctx);
        g  = mgrant();
        ar = !ma.full || g == 1;
        br = !mb.full || g == 2;
        @(posedge clk);
        if (!ma.full || g == 1) mstarve = 0;
        else if (mstarve < 15) mstarve = mstarve + 1;
        if (av && ar)   ma = '{1'b1, aa, ad, edge_no};
        else if (g == 1) ma.full = 1'b0;
        if (bv && br)   mb = '{1'b1, ba, bd, edge_no};
        else if (g == 2) mb.full = 1'b0;
        edge_no++;
        #1;
    endtask

    task automatic idle(input string ctx);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, ctx);
    endtask

    initial begin
        edge_no = 0;
        model_reset();
        reset   = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs("reset");

        // A alone: written the next cycle, A stays ready throughout.
        step(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0, "a_only.load");
        check("a_only.addr", 32'(write_addr3), 32'd3);
        check("a_only.data", write_data3, 32'h11);
        idle("a_only.drain");

        // Different addresses loaded together: B (r5) first, then A (r2).
        step(1'b1, 4'd2, 32'hA2, 1'b1, 4'd5, 32'hB5, "both.load");
        check("both.first", 32'(write_addr3), 32'd5);
        idle("both.c1");
        check("both.second", 32'(write_addr3), 32'd2);
        idle("both.c2");

        // Same address loaded together: B is older.
        step(1'b1, 4'd7, 32'hA7, 1'b1, 4'd7, 32'hB7, "same.load");
        check("same.first", write_data3, 32'hB7);
        idle("same.c1");
        check("same.second", write_data3, 32'hA7);
        idle("same.c2");

        // A held full while B streams: A wins once the counter reaches the
        // limit, and B wins the very next collision because the count cleared.
        step(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2, "starve.load");
        repeat (SL) step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'hB2, "starve.stream");
        check("starve.a_wins", 32'(write_addr3), 32'd1);
        step(1'b1, 4'd3, 32'hA3, 1'b1, 4'd2, 32'hB2, "starve.grant");
        check("starve.cleared", 32'(write_addr3), 32'd2);
        idle("starve.d1");
        idle("starve.d2");

        // B loaded with r7 while A is full, then A reloaded with r7 while
        // B still holds its entry: B's write goes first.
        step(1'b1, 4'd4, 32'hA4, 1'b1, 4'd1, 32'hB1, "order.load");
        repeat (SL - 1) step(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'hB1, "order.stream");
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'hB7, "order.b7");
        check("order.a_starved", 32'(write_addr3), 32'd4);
        step(1'b1, 4'd7, 32'hA7, 1'b0, 4'd0, 32'd0, "order.a7");
        check("order.first", write_data3, 32'hB7);
        idle("order.c1");
        check("order.second", write_data3, 32'hA7);
        idle("order.c2");

        // r15 goes to the PC port, not the register file.
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'hF, 32'h100, "pc.load");
        check("pc.we", 32'(pc_write_enable), 32'd1);
        check("pc.data", pc_write_data, 32'h100);
        check("pc.rf_we", 32'(write_enable3), 32'd0);
`ifdef REG_WRITE_ARB_PENDING_EN
        check("pc.mask", 32'(pending_mask), 32'h8000);
`endif
        idle("pc.drain");

        // Reset with both slots full: enables drop at once, nothing is written.
        step(1'b1, 4'd6, 32'hA6, 1'b1, 4'd9, 32'hB9, "rst.load");
        #2;
        reset = 1'b1;
        #1;
        check("rst.we_async", 32'(write_enable3), 32'd0);
        check("rst.a_ready", 32'(a_ready), 32'd1);
        check("rst.b_ready", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst.we_held", 32'(write_enable3), 32'd0);
        check("rst.pc_we_held", 32'(pc_write_enable), 32'd0);
        reset = 1'b0;
        model_reset();
        idle("rst.after");

        // Random traffic over a small address set so collisions and r15 occur.
        for (int i = 0; i < 400; i++) begin
            bit [3:0] ra, rb;
            ra = 4'($urandom_range(0, 3));
            rb = 4'($urandom_range(0, 3));
            if (ra == 4'd3) ra = 4'hF;
            if (rb == 4'd3) rb = 4'hF;
            step(1'($urandom_range(0, 1)), ra, $urandom(),
                 1'($urandom_range(0, 1)), rb, $urandom(), "rand");
        end
        repeat (3) idle("rand.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
